ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- Pipeline register plus operand-forwarding stage directly upstream of the 64-bit ALU.
- Captures decoded instructions from ID, resolves RAW hazards against the MEM and WB stages, and drives the ALU's A, B and op inputs.
- Handshakes on both sides; holds its slot under downstream backpressure or a load-use hazard.

Parameters:
- XLEN, 64, datapath width (ALU operand width).
- REG_IDX_W, 5, register index width; index 0 is hardwired zero.
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of the held instruction (branch mispredict).
- id_valid  in  1  ID presents an instruction.
- id_ready  out  1  stage accepts an instruction this cycle.
- id_rs1_idx, id_rs2_idx  in  REG_IDX_W  source indices.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_use_imm  in  1  B operand = immediate instead of rs2.
- id_alu_op  in  OP_W  ALU opcode.
- id_rd  in  REG_IDX_W  destination index.
- id_reg_write  in  1  instruction writes rd.
- mem_fwd_valid  in  1  MEM-stage instruction writes mem_fwd_rd.
- mem_fwd_rd  in  REG_IDX_W  MEM-stage destination.
- mem_fwd_data  in  XLEN  MEM-stage result.
- mem_fwd_pending  in  1  MEM result not yet available (load in flight).
- wb_fwd_valid  in  1  WB-stage instruction writes wb_fwd_rd.
- wb_fwd_rd  in  REG_IDX_W  WB destination.
- wb_fwd_data  in  XLEN  WB result.
- ex_ready  in  1  downstream consumes the ALU result this cycle.
- ex_valid  out  1  alu_a/alu_b/alu_op/ex_rd are valid.
- alu_a, alu_b  out  XLEN  ALU operands.
- alu_op  out  OP_W  ALU opcode.
- ex_rd  out  REG_IDX_W  destination passed downstream.
- ex_reg_write  out  1  write-enable passed downstream.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: slot empty; ex_valid=0, alu_op=0, ex_rd=0, ex_reg_write=0; stored operands, immediate and indices=0. With both forward valids low, alu_a=alu_b=0.
- Slot FSM states:
  - EMPTY: no instruction held.
  - FULL: held, no hazard.
  - STALL: held, load-use hazard.
- Hazard definition:
  - need_rsX = source used; rs2 counts only when use_imm=0.
  - Hazard = needed source idx != 0, mem_fwd_valid, idx == mem_fwd_rd, mem_fwd_pending.
  - Evaluated combinationally every cycle on the held instruction.
- Outputs by state:
  - ex_valid = FULL. STALL inserts a bubble: ex_valid=0 and the slot is held.
- Ready and capture:
  - id_ready = EMPTY | (FULL & ex_ready).
  - Capture on id_valid & id_ready: EMPTY/FULL → FULL or STALL, per the hazard computed on the new contents next cycle.
  - FULL & ex_ready & no capture → EMPTY.
  - STALL → FULL when mem_fwd_pending drops or MEM no longer matches.
- Forwarding, per operand, combinational, priority order:
  - 1. Index 0 → 0.
  - 2. MEM match (valid & rd equal) → mem_fwd_data.
  - 3. WB match → wb_fwd_data.
  - 4. Stored register data.
  - alu_b = stored imm when use_imm=1. Latency from capture to ALU inputs: 1 cycle.
- Flush:
  - Empties the slot next cycle and overrides capture: a same-cycle id handshake is dropped.
  - id_ready is still computed normally, so ID sees the transfer as complete.
- Reset mid-stall: slot emptied, no pending state retained.
- Simultaneous MEM and WB match on the same rd: MEM wins (younger).
- Values are pure passthrough; no arithmetic in this block. Widths are exact, no extension beyond what ID provides.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - No forwarding muxes; operands come from stored data only.
  - Hazard becomes any needed nonzero source matching a valid MEM or WB rd, regardless of pending. Result: STALL until cleared.
  - The register file then supplies the value; stored data is refreshed from id_rs*_data while in STALL.

Decomposition:
- Shared package cpu_pkg:
  - XLEN, REG_IDX_W, OP_W.
  - ALU opcode constants ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_EQ=4'd4.
  - Slot state encoding.
- One sub-module: operand_fwd_mux, instantiated twice (rs1, rs2), implementing the zero/MEM/WB/stored priority.

Test Plan:
- Reset: rst=1 for 2 cycles → ex_valid=0, alu_op=0, alu_a=alu_b=0, id_ready=1.
- Capture, no hazard: issue rs1=3 (data 1), rs2=4 (data 4), op=ALU_ADD, ex_ready=1 → next cycle ex_valid=1, alu_a=1, alu_b=4, alu_op=0.
- MEM forward: held rs1=5, stored 2; mem_fwd_valid=1, rd=5, data=64'hFFFF_FFFF_FFFF_FFFF, pending=0 → alu_a=all-ones. Same-cycle WB match on rd=5 with data 7 → still all-ones.
- Load-use stall: rs2=6, mem rd=6, pending=1 for 2 cycles → ex_valid=0 and id_ready=0 for 2 cycles. Pending drops with data 3 → ex_valid=1, alu_b=3, op=ALU_SUB.
- Backpressure and flush:
  - ex_ready=0 with slot FULL → id_ready=0 and outputs stable.
  - Then flush=1 with id_valid=1 → next cycle ex_valid=0; the new instruction is dropped.
- Zero register and immediate: rs1=0 with mem rd=0 valid, data 9 → alu_a=0. Then use_imm=1, imm=2, op=ALU_EQ → alu_b=2, no stall even if rs2 matches a pending MEM rd.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, ALU opcodes, slot state encoding and held-slot layout.
package cpu_pkg;
   localparam int XLEN = 64;
   localparam int REG_IDX_W = 5;
   localparam int OP_W = 4;
   localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
   localparam logic [OP_W-1:0] ALU_EQ = 4'd4;
   typedef enum logic [1:0] {SLOT_EMPTY, SLOT_FULL, SLOT_STALL} slot_state_e;
   typedef struct packed {
      logic [REG_IDX_W-1:0] rs1_idx;
      logic [REG_IDX_W-1:0] rs2_idx;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic use_imm;
      logic [OP_W-1:0] alu_op;
      logic [REG_IDX_W-1:0] rd;
      logic reg_write;
   } slot_t;
endpackage

// File: rtl/ex_operand_stage_if.sv
// ex_operand_stage_if: ID capture, MEM/WB forwarding, flush and ALU-side handshake bundle.
interface ex_operand_stage_if;
   import cpu_pkg::*;
   logic flush;
   logic id_valid;
   logic id_ready;
   logic [REG_IDX_W-1:0] id_rs1_idx;
   logic [REG_IDX_W-1:0] id_rs2_idx;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic id_use_imm;
   logic [OP_W-1:0] id_alu_op;
   logic [REG_IDX_W-1:0] id_rd;
   logic id_reg_write;
   logic mem_fwd_valid;
   logic [REG_IDX_W-1:0] mem_fwd_rd;
   logic [XLEN-1:0] mem_fwd_data;
   logic mem_fwd_pending;
   logic wb_fwd_valid;
   logic [REG_IDX_W-1:0] wb_fwd_rd;
   logic [XLEN-1:0] wb_fwd_data;
   logic ex_ready;
   logic ex_valid;
   logic [XLEN-1:0] alu_a;
   logic [XLEN-1:0] alu_b;
   logic [OP_W-1:0] alu_op;
   logic [REG_IDX_W-1:0] ex_rd;
   logic ex_reg_write;
   modport slave (
      input flush, id_valid, id_rs1_idx, id_rs2_idx, id_rs1_data, id_rs2_data, id_imm,
      input id_use_imm, id_alu_op, id_rd, id_reg_write,
      input mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_pending,
      input wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
      output id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rd, ex_reg_write
   );
   modport master (
      output flush, id_valid, id_rs1_idx, id_rs2_idx, id_rs1_data, id_rs2_data, id_imm,
      output id_use_imm, id_alu_op, id_rd, id_reg_write,
      output mem_fwd_valid, mem_fwd_rd, mem_fwd_data, mem_fwd_pending,
      output wb_fwd_valid, wb_fwd_rd, wb_fwd_data, ex_ready,
      input id_ready, ex_valid, alu_a, alu_b, alu_op, ex_rd, ex_reg_write
   );
endinterface

// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: one ALU operand with zero-register / MEM / WB / stored-data priority.
module operand_fwd_mux
   import cpu_pkg::*;
(
   input  logic [REG_IDX_W-1:0] idx,
   input  logic [XLEN-1:0] stored,
   input  logic mem_v,
   input  logic [REG_IDX_W-1:0] mem_rd,
   input  logic [XLEN-1:0] mem_data,
   input  logic wb_v,
   input  logic [REG_IDX_W-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] q
);
   always_comb q = idx == '0 ? '0 : (mem_v && idx == mem_rd) ? mem_data : (wb_v && idx == wb_rd) ? wb_data : stored;
endmodule

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: EX pipeline slot with RAW hazard handling feeding the ALU.
// EX_FORWARD_EN enables MEM/WB forwarding; without it any MEM/WB match stalls until the register file catches up.
module ex_operand_stage
   import cpu_pkg::*;
(
   input logic clk,
   input logic rst,
   ex_operand_stage_if.slave bus
);
`ifdef EX_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif
   slot_state_e state_q, state_d, cur;
   slot_t slot_q, slot_d;
   logic need1, need2, m1, m2, w1, w2, haz, id_rdy, capture, mem_v, wb_v;
   logic [XLEN-1:0] fwd_a, fwd_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SLOT_EMPTY;
         slot_q <= '0;
      end else begin
         state_q <= state_d;
         slot_q <= slot_d;
      end
   end

   // Hazard is re-evaluated each cycle on the held slot, so FULL/STALL is resolved live.
   always_comb begin
      need1 = slot_q.rs1_idx != '0;
      need2 = !slot_q.use_imm && slot_q.rs2_idx != '0;
      m1 = bus.mem_fwd_valid && slot_q.rs1_idx == bus.mem_fwd_rd;
      m2 = bus.mem_fwd_valid && slot_q.rs2_idx == bus.mem_fwd_rd;
      w1 = bus.wb_fwd_valid && slot_q.rs1_idx == bus.wb_fwd_rd;
      w2 = bus.wb_fwd_valid && slot_q.rs2_idx == bus.wb_fwd_rd;
      haz = FWD_EN ? bus.mem_fwd_pending && ((need1 && m1) || (need2 && m2))
                   : (need1 && (m1 || w1)) || (need2 && (m2 || w2));
      cur = state_q == SLOT_EMPTY ? SLOT_EMPTY : haz ? SLOT_STALL : SLOT_FULL;
   end

   always_comb begin
      id_rdy = cur == SLOT_EMPTY || (cur == SLOT_FULL && bus.ex_ready);
      capture = bus.id_valid && id_rdy && !bus.flush;
      state_d = bus.flush ? SLOT_EMPTY : capture ? SLOT_FULL : (cur == SLOT_FULL && bus.ex_ready) ? SLOT_EMPTY : cur;
      slot_d = slot_q;
      if (capture) begin
         slot_d.rs1_idx = bus.id_rs1_idx;
         slot_d.rs2_idx = bus.id_rs2_idx;
         slot_d.rs1_data = bus.id_rs1_data;
         slot_d.rs2_data = bus.id_rs2_data;
         slot_d.imm = bus.id_imm;
         slot_d.use_imm = bus.id_use_imm;
         slot_d.alu_op = bus.id_alu_op;
         slot_d.rd = bus.id_rd;
         slot_d.reg_write = bus.id_reg_write;
      end else if (!FWD_EN && cur == SLOT_STALL) begin
         slot_d.rs1_data = bus.id_rs1_data;
         slot_d.rs2_data = bus.id_rs2_data;
      end
   end

   assign mem_v = FWD_EN && bus.mem_fwd_valid;
   assign wb_v = FWD_EN && bus.wb_fwd_valid;

   operand_fwd_mux u_fwd_a (
      .idx(slot_q.rs1_idx), .stored(slot_q.rs1_data),
      .mem_v(mem_v), .mem_rd(bus.mem_fwd_rd), .mem_data(bus.mem_fwd_data),
      .wb_v(wb_v), .wb_rd(bus.wb_fwd_rd), .wb_data(bus.wb_fwd_data), .q(fwd_a)
   );

   operand_fwd_mux u_fwd_b (
      .idx(slot_q.rs2_idx), .stored(slot_q.rs2_data),
      .mem_v(mem_v), .mem_rd(bus.mem_fwd_rd), .mem_data(bus.mem_fwd_data),
      .wb_v(wb_v), .wb_rd(bus.wb_fwd_rd), .wb_data(bus.wb_fwd_data), .q(fwd_b)
   );

   always_comb begin
      bus.id_ready = id_rdy;
      bus.ex_valid = cur == SLOT_FULL;
      bus.alu_a = fwd_a;
      bus.alu_b = slot_q.use_imm ? slot_q.imm : fwd_b;
      bus.alu_op = slot_q.alu_op;
      bus.ex_rd = slot_q.rd;
      bus.ex_reg_write = slot_q.reg_write;
   end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed scoreboard bench for ex_operand_stage (both EX_FORWARD_EN builds).
module tb_ex_operand_stage;
   import cpu_pkg::*;
   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0] op;
      logic [4:0] rd;
   } out_t;
   typedef struct {
      int tag;
      bit ev;
      bit ir;
      bit chk;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0] op;
      logic [4:0] rd;
      logic rw;
   } ctl_t;

   logic clk, rst;
   bit done;
   int checks, errors, cyc, step;
   out_t exp_q[$];
   ctl_t ctl_q[$];
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   ex_operand_stage_if ifc ();
   ex_operand_stage dut (.clk(clk), .rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifc.id_valid = 1'b0;
      ifc.flush = 1'b0;
      ifc.mem_fwd_valid = 1'b0;
      ifc.mem_fwd_pending = 1'b0;
      ifc.wb_fwd_valid = 1'b0;
   endtask

   task automatic fwd_mem(input logic [4:0] rd, input logic [63:0] d, input logic pend);
      ifc.mem_fwd_valid = 1'b1;
      ifc.mem_fwd_rd = rd;
      ifc.mem_fwd_data = d;
      ifc.mem_fwd_pending = pend;
   endtask

   task automatic issue(input logic [4:0] r1, input logic [63:0] d1, input logic [4:0] r2,
                        input logic [63:0] d2, input logic [63:0] im, input logic ui,
                        input logic [3:0] op, input logic [4:0] rd);
      idle();
      ifc.id_valid = 1'b1;
      ifc.id_rs1_idx = r1;
      ifc.id_rs1_data = d1;
      ifc.id_rs2_idx = r2;
      ifc.id_rs2_data = d2;
      ifc.id_imm = im;
      ifc.id_use_imm = ui;
      ifc.id_alu_op = op;
      ifc.id_rd = rd;
      ifc.id_reg_write = 1'b1;
   endtask

   task automatic expo(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op, input logic [4:0] rd);
      out_t e;
      e.a = a;
      e.b = b;
      e.op = op;
      e.rd = rd;
      exp_q.push_back(e);
   endtask

   task automatic ctl(input bit ev, input bit ir, input bit chk, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] op, input logic [4:0] rd, input logic rw);
      ctl_t c;
      step++;
      c.tag = step;
      c.ev = ev;
      c.ir = ir;
      c.chk = chk;
      c.a = a;
      c.b = b;
      c.op = op;
      c.rd = rd;
      c.rw = rw;
      ctl_q.push_back(c);
   endtask

   // Single checker process: per-cycle control expectations plus in-order ALU-output scoreboard.
   always @(negedge clk) begin
      ctl_t c;
      out_t e;
      cyc++;
      if (ctl_q.size() != 0) begin
         c = ctl_q.pop_front();
         checks++;
         if ({ifc.ex_valid, ifc.id_ready} !== {c.ev, c.ir}) begin
            errors++;
            $display("FAIL ctl_%0d: ex_valid/id_ready got %b%b want %b%b", c.tag, ifc.ex_valid, ifc.id_ready, c.ev, c.ir);
         end
         if (c.chk) begin
            checks++;
            if ({ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.ex_rd, ifc.ex_reg_write} !== {c.a, c.b, c.op, c.rd, c.rw}) begin
               errors++;
               $display("FAIL data_%0d: got a=%h b=%h op=%0d rd=%0d rw=%b want a=%h b=%h op=%0d rd=%0d rw=%b",
                        c.tag, ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.ex_rd, ifc.ex_reg_write, c.a, c.b, c.op, c.rd, c.rw);
            end
         end
      end
      if (!rst && ifc.ex_valid && ifc.ex_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got a=%h b=%h rd=%0d want no transfer", ifc.alu_a, ifc.alu_b, ifc.ex_rd);
         end else begin
            e = exp_q.pop_front();
            if ({ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.ex_rd, ifc.ex_reg_write} !== {e.a, e.b, e.op, e.rd, 1'b1}) begin
               errors++;
               $display("FAIL out_rd%0d: got a=%h b=%h op=%0d rd=%0d rw=%b want a=%h b=%h op=%0d rd=%0d rw=1",
                        e.rd, ifc.alu_a, ifc.alu_b, ifc.alu_op, ifc.ex_rd, ifc.ex_reg_write, e.a, e.b, e.op, e.rd);
            end
         end
      end
      if (done || cyc > 2000) begin
         checks++;
         if (cyc > 2000) begin
            errors++;
            $display("FAIL timeout: got %0d cycles want done", cyc);
         end
         if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outstanding outputs want 0", exp_q.size());
         end
         $display("Simulation finished: %0d checks, %0d errors", checks, errors);
         $finish;
      end
   end

   initial begin
      rst = 1'b1;
      idle();
      ifc.ex_ready = 1'b1;
      issue(0, 0, 0, 0, 0, 0, ALU_ADD, 0);
      idle();
      ifc.mem_fwd_rd = '0;
      ifc.mem_fwd_data = '0;
      ifc.wb_fwd_rd = '0;
      ifc.wb_fwd_data = '0;
      ifc.id_reg_write = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      ctl(0, 1, 1, 0, 0, ALU_ADD, 0, 0);
      tick();
      // plain capture
      issue(3, 1, 4, 4, 0, 0, ALU_ADD, 10);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      expo(1, 4, ALU_ADD, 10);
      tick();
      idle();
      ctl(1, 1, 1, 1, 4, ALU_ADD, 10, 1);
      tick();
      // MEM beats WB on the same rd
      issue(5, 2, 0, 0, 0, 0, ALU_ADD, 11);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      expo(ONES, 0, ALU_ADD, 11);
      tick();
      idle();
      fwd_mem(5, ONES, 0);
      ifc.wb_fwd_valid = 1'b1;
      ifc.wb_fwd_rd = 5;
      ifc.wb_fwd_data = 7;
      ifc.id_rs1_data = ONES;
`ifdef EX_FORWARD_EN
      ctl(1, 1, 1, ONES, 0, ALU_ADD, 11, 1);
`else
      ctl(0, 0, 0, 0, 0, 0, 0, 0);
`endif
      tick();
      idle();
`ifdef EX_FORWARD_EN
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
`else
      ctl(1, 1, 1, ONES, 0, ALU_ADD, 11, 1);
`endif
      tick();
      // load-use stall on rs2
      issue(0, 0, 6, 8, 0, 0, ALU_SUB, 12);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      expo(0, 3, ALU_SUB, 12);
      tick();
      repeat (2) begin
         idle();
         fwd_mem(6, 64'h55, 1);
         ifc.id_rs2_data = 3;
         ctl(0, 0, 0, 0, 0, 0, 0, 0);
         tick();
      end
      idle();
`ifdef EX_FORWARD_EN
      fwd_mem(6, 3, 0);
`endif
      ctl(1, 1, 1, 0, 3, ALU_SUB, 12, 1);
      tick();
      // backpressure, then flush of the held slot
      issue(7, 5, 8, 6, 0, 0, ALU_ADD, 13);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      ifc.ex_ready = 1'b0;
      repeat (2) begin
         ctl(1, 0, 1, 5, 6, ALU_ADD, 13, 1);
         tick();
      end
      ifc.flush = 1'b1;
      ctl(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      issue(9, 99, 1, 1, 0, 0, ALU_ADD, 20);
      ifc.flush = 1'b1;
      ifc.ex_ready = 1'b1;
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      // x0 never forwards or stalls
      issue(0, 0, 0, 0, 0, 0, ALU_ADD, 14);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      expo(0, 0, ALU_ADD, 14);
      tick();
      idle();
      fwd_mem(0, 9, 1);
      ctl(1, 1, 1, 0, 0, ALU_ADD, 14, 1);
      tick();
      // immediate B operand masks an rs2 match
      issue(0, 0, 6, 0, 2, 1, ALU_EQ, 15);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      expo(0, 2, ALU_EQ, 15);
      tick();
      idle();
      fwd_mem(6, 9, 1);
      ctl(1, 1, 1, 0, 2, ALU_EQ, 15, 1);
      tick();
      // WB-only match on rs1
      issue(3, 1, 0, 0, 0, 0, ALU_ADD, 16);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      expo(64'h77, 0, ALU_ADD, 16);
      tick();
      idle();
      ifc.wb_fwd_valid = 1'b1;
      ifc.wb_fwd_rd = 3;
      ifc.wb_fwd_data = 64'h77;
      ifc.id_rs1_data = 64'h77;
`ifdef EX_FORWARD_EN
      ctl(1, 1, 1, 64'h77, 0, ALU_ADD, 16, 1);
`else
      ctl(0, 0, 0, 0, 0, 0, 0, 0);
`endif
      tick();
      idle();
`ifdef EX_FORWARD_EN
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
`else
      ctl(1, 1, 1, 64'h77, 0, ALU_ADD, 16, 1);
`endif
      tick();
      // reset while stalled
      issue(0, 0, 6, 0, 0, 0, ALU_ADD, 17);
      ctl(0, 1, 0, 0, 0, 0, 0, 0);
      tick();
      idle();
      fwd_mem(6, 9, 1);
      ctl(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ctl(0, 1, 1, 0, 0, ALU_ADD, 0, 0);
      tick();
      idle();
      tick();
      done = 1'b1;
   end
endmodule
